// File: rtl/wb_arbiter.sv
// Writeback collector: per-source result FIFOs drained round-robin onto a
// single scoreboard writeback port with a valid/ready handshake.
// Optional build macro WB_ARB_BYPASS_EN: when every FIFO is empty an incoming
// result is forwarded to the writeback port in the same cycle.
// The exception payload is carried as an opaque EXC_W-bit vector.
module wb_arbiter #(
  parameter int unsigned NR_SRC        = 5,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned EXC_W         = 8,
  localparam int unsigned SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic [NR_SRC-1:0]               src_valid_i,
  output logic [NR_SRC-1:0]               src_ready_o,
  input  logic [NR_SRC*TRANS_ID_BITS-1:0] src_trans_id_i,
  input  logic [NR_SRC*64-1:0]            src_result_i,
  input  logic [NR_SRC*EXC_W-1:0]         src_exception_i,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic [SRC_W-1:0]                wb_src_o,
  output logic [TRANS_ID_BITS-1:0]        wb_trans_id_o,
  output logic [63:0]                     wb_result_o,
  output logic [EXC_W-1:0]                wb_exception_o,
  output logic                            overflow_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = TRANS_ID_BITS + 64 + EXC_W;
  // read/write pointers differ only in the wrap bit when the FIFO is full
  localparam logic [PW-1:0] FULL_XOR = PW'(1) << (PW - 1);

  typedef logic [EW-1:0] entry_t;

  entry_t          mem_q  [NR_SRC][FIFO_DEPTH];
  logic [PW-1:0]   wptr_q [NR_SRC];
  logic [PW-1:0]   rptr_q [NR_SRC];
  logic [SRC_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [SRC_W-1:0] lock_idx_q, lock_idx_d;
  logic             overflow_q, overflow_d;

  logic [NR_SRC-1:0] full, nempty, push, pop;
  entry_t            in_entry [NR_SRC];
  entry_t            head     [NR_SRC];
  entry_t            wb_entry;
  logic              fifo_found, bypass, wb_valid, accept;
  logic [SRC_W-1:0]  fifo_idx, grant_idx;
`ifdef WB_ARB_BYPASS_EN
  logic              byp_found;
  logic [SRC_W-1:0]  byp_idx;
`endif

  function automatic logic [AW-1:0] slot(input logic [PW-1:0] p);
    if (FIFO_DEPTH == 1) return '0;
    else                 return p[AW-1:0];
  endfunction

  // First requester at or after start, wrapping; returns {found, index}.
  function automatic logic [SRC_W:0] rr_pick(input logic [NR_SRC-1:0] req,
                                             input logic [SRC_W-1:0]  start);
    logic             found;
    logic [SRC_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(NR_SRC); k++) begin
      j = int'(start) + k;
      if (j >= int'(NR_SRC)) j -= int'(NR_SRC);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SRC_W'(j);
      end
    end
    return {found, idx};
  endfunction

  // Per-FIFO status, incoming entry packing and head-of-queue view
  always_comb begin
    for (int i = 0; i < int'(NR_SRC); i++) begin
      full[i]     = (wptr_q[i] ^ rptr_q[i]) == FULL_XOR;
      nempty[i]   = wptr_q[i] != rptr_q[i];
      in_entry[i] = {src_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS],
                     src_result_i[i*64 +: 64],
                     src_exception_i[i*EXC_W +: EXC_W]};
      head[i]     = mem_q[i][slot(rptr_q[i])];
    end
  end

  // Grant selection, handshake, push/pop decode and next-state
  always_comb begin
    {fifo_found, fifo_idx} = rr_pick(nempty, rr_q);
    // a stalled grant is held so a newly filled earlier source cannot steal it
    grant_idx = lock_q ? lock_idx_q : fifo_idx;
    bypass    = 1'b0;
    wb_entry  = head[grant_idx];
`ifdef WB_ARB_BYPASS_EN
    {byp_found, byp_idx} = rr_pick(src_valid_i, rr_q);
    if (!fifo_found && byp_found) begin
      bypass    = 1'b1;
      grant_idx = byp_idx;
      wb_entry  = in_entry[byp_idx];
    end
`endif
    wb_valid = (fifo_found || bypass) && !flush_i;
    accept   = wb_valid && wb_ready_i;

    for (int i = 0; i < int'(NR_SRC); i++) begin
      push[i] = src_valid_i[i] && !full[i] && !flush_i;
      pop[i]  = accept && !bypass && (grant_idx == SRC_W'(i));
    end
    // an accepted bypass entry never lands in its FIFO
    if (bypass && accept) push[grant_idx] = 1'b0;

    overflow_d = overflow_q | (|(src_valid_i & full & ~{NR_SRC{flush_i}}));

    rr_d = rr_q;
    if (accept)
      rr_d = (grant_idx == SRC_W'(NR_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);

    lock_d     = wb_valid && !wb_ready_i;
    lock_idx_d = grant_idx;
  end

  // Output drive; data is forced to zero whenever nothing is presented
  always_comb begin
    src_ready_o    = ~full;
    wb_valid_o     = wb_valid;
    wb_src_o       = wb_valid ? grant_idx : '0;
    wb_trans_id_o  = wb_valid ? wb_entry[EW-1 -: TRANS_ID_BITS] : '0;
    wb_result_o    = wb_valid ? wb_entry[EXC_W +: 64] : '0;
    wb_exception_o = wb_valid ? wb_entry[EXC_W-1:0] : '0;
    overflow_o     = overflow_q;
  end

  // Arbiter state: round-robin pointer, stall lock, sticky overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO pointers; flush empties every FIFO at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_SRC); i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < int'(NR_SRC); i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NR_SRC); i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by the pointers so need no reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NR_SRC); i++) begin
      if (push[i]) mem_q[i][slot(wptr_q[i])] <= in_entry[i];
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (default build): directed scenarios then random traffic,
// checked every cycle against a queue-based model of the arbitration rules.
module tb_wb_arbiter;

  localparam int N  = 5;
  localparam int D  = 2;
  localparam int TW = 3;
  localparam int XW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    sv = '0;
  logic [N-1:0]    srdy;
  logic [N*TW-1:0] sid = '0;
  logic [N*64-1:0] sres = '0;
  logic [N*XW-1:0] sexc = '0;
  logic            wvalid;
  logic            wready = 1'b0;
  logic [2:0]      wsrc;
  logic [TW-1:0]   wid;
  logic [63:0]     wres;
  logic [XW-1:0]   wexc;
  logic            ovf;

  wb_arbiter #(.NR_SRC(N), .FIFO_DEPTH(D), .TRANS_ID_BITS(TW), .EXC_W(XW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .src_valid_i(sv), .src_ready_o(srdy),
    .src_trans_id_i(sid), .src_result_i(sres), .src_exception_i(sexc),
    .wb_valid_o(wvalid), .wb_ready_i(wready), .wb_src_o(wsrc),
    .wb_trans_id_o(wid), .wb_result_o(wres), .wb_exception_o(wexc),
    .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] id;
    logic [63:0]   res;
    logic [XW-1:0] exc;
  } ent_t;

  // reference model: one queue per source plus arbitration bookkeeping
  ent_t mq [N][$];
  int   rr_m;
  bit   held_m;
  int   held_src;
  bit   ovf_m;
  int   total = 0;
  int   bad = 0;
  int   nprint = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (nprint < 40) $display("FAIL %s got=%0h want=%0h at t=%0t", name, act, exp, $time);
      nprint++;
    end
  endtask

  // model + monitor: sample at the falling edge, predict the next rising edge
  int   cnt [N];
  bit   any, exp_valid;
  int   g, s;
  ent_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr_m = 0; held_m = 0; held_src = 0; ovf_m = 0;
      check("rst_valid", wvalid, 0);
      check("rst_ready", srdy, {N{1'b1}});
      check("rst_ovf", ovf, 0);
      check("rst_data", wres, 0);
      check("rst_meta", {wsrc, wid, wexc}, 0);
    end else begin
      any = 0; g = 0;
      if (held_m) begin
        any = 1; g = held_src;
      end else begin
        for (int k = 0; k < N; k++) begin
          s = (rr_m + k) % N;
          if (!any && mq[s].size() > 0) begin any = 1; g = s; end
        end
      end
      exp_valid = any && !flush;
      check("valid", wvalid, exp_valid);
      for (int i = 0; i < N; i++) check("src_ready", srdy[i], mq[i].size() < D);
      check("overflow", ovf, ovf_m);
      if (exp_valid) begin
        e = mq[g][0];
        check("wb_src", wsrc, g);
        check("wb_id", wid, e.id);
        check("wb_result", wres, e.res);
        check("wb_exc", wexc, e.exc);
      end else begin
        check("idle_result", wres, 0);
        check("idle_meta", {wsrc, wid, wexc}, 0);
      end
      if (flush) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        held_m = 0;
      end else begin
        for (int i = 0; i < N; i++) cnt[i] = mq[i].size();
        if (exp_valid && wready) begin
          void'(mq[g].pop_front());
          rr_m = (g + 1) % N;
          held_m = 0;
        end else if (exp_valid) begin
          held_m = 1; held_src = g;
        end
        for (int i = 0; i < N; i++) begin
          if (sv[i]) begin
            if (cnt[i] < D) begin
              e.id  = sid[i*TW +: TW];
              e.res = sres[i*64 +: 64];
              e.exc = sexc[i*XW +: XW];
              mq[i].push_back(e);
            end else begin
              ovf_m = 1;
            end
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_src(input int i, input logic [TW-1:0] id, input logic [63:0] r,
                         input logic [XW-1:0] x);
    sv[i] = 1'b1;
    sid[i*TW +: TW] = id;
    sres[i*64 +: 64] = r;
    sexc[i*XW +: XW] = x;
  endtask

  task automatic idle();
    sv = '0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    wready = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  int rdy_pct;
  initial begin
    @(posedge clk); #1;
    do_reset();

    // single push from source 1
    wready = 1'b1;
    set_src(1, 3'd3, 64'hDEAD, 8'h00);
    step(1); idle(); step(3);

    // all sources at once from rr=0
    do_reset();
    wready = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, TW'(i + 1), 64'h1000 + 64'(i), XW'(i));
    step(1); idle(); step(7);

    // overfill source 3 while stalled; overflow must stick after draining
    do_reset();
    wready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_src(3, TW'(k + 1), 64'h3300 + 64'(k), 8'h33);
      step(1);
    end
    idle(); step(2);
    wready = 1'b1; step(6);

    // stall with source 2 granted, then source 0 fills
    do_reset();
    wready = 1'b0;
    set_src(2, 3'd5, 64'hBEEF, 8'h07);
    step(1); idle(); step(4);
    set_src(0, 3'd6, 64'hCAFE, 8'h01);
    step(1); idle(); step(2);
    wready = 1'b1; step(4);

    // source 4 full, flush with concurrent pushes (one into the full FIFO)
    do_reset();
    wready = 1'b0;
    set_src(4, 3'd1, 64'h4401, 8'h44); step(1);
    set_src(4, 3'd2, 64'h4402, 8'h44); step(1);
    idle();
    flush = 1'b1;
    set_src(1, 3'd4, 64'h1104, 8'h11);
    set_src(4, 3'd3, 64'h4403, 8'h44);
    step(1); idle(); step(3);

    // stream 10 entries through source 0
    wready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_src(0, TW'(k), 64'h5000 + 64'(k), XW'(k));
      step(1);
    end
    idle(); step(4);

    // random traffic with varying backpressure; reset also clears overflow
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      rdy_pct = $urandom_range(10, 100);
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < N; i++) begin
          sv[i] = ($urandom_range(0, 99) < 35);
          sid[i*TW +: TW] = TW'($urandom);
          sres[i*64 +: 64] = {$urandom, $urandom};
          sexc[i*XW +: XW] = XW'($urandom);
        end
        wready = ($urandom_range(0, 99) < rdy_pct);
        flush = ($urandom_range(0, 59) == 0);
        step(1);
      end
      if (blk == 10) do_reset();
    end
    idle(); wready = 1'b1; step(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback collector directly downstream of the execute stage.
- Takes the independent result streams (FLU, load, store, FPU, RoCC) into per-source FIFOs.
- Arbitrates them round-robin onto a single scoreboard writeback port with a valid/ready handshake.
- Decouples bursty multi-unit completion from a narrower scoreboard write interface.

Parameters:
- NR_SRC, 5, number of result sources; index 0=FLU, 1=load, 2=store, 3=FPU, 4=RoCC.
- FIFO_DEPTH, 2, entries per source FIFO; must be a power of two and at least 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush; discards all buffered results.
- src_valid_i  in  NR_SRC  per-source result valid.
- src_ready_o  out  NR_SRC  per-source FIFO not full.
- src_trans_id_i  in  NR_SRC*TRANS_ID_BITS  scoreboard IDs, packed; source i at slice i.
- src_result_i  in  NR_SRC*64  results, packed.
- src_exception_i  in  NR_SRC x exception_t  per-source exception.
- wb_valid_o  out  1  writeback entry valid.
- wb_ready_i  in  1  scoreboard accepts the entry.
- wb_src_o  out  $clog2(NR_SRC)  index of the granted source.
- wb_trans_id_o  out  TRANS_ID_BITS  ID of the granted entry.
- wb_result_o  out  64  result of the granted entry.
- wb_exception_o  out  exception_t  exception of the granted entry.
- overflow_o  out  1  sticky error: a push was dropped because a FIFO was full.

Behaviour:
- Reset (async, rst_ni=0):
  - All FIFOs empty; rr pointer=0; overflow_o=0; wb_valid_o=0.
  - wb_src_o, wb_trans_id_o, wb_result_o and wb_exception_o are all 0.
  - src_ready_o all 1.
- Push: src_valid_i[i] & src_ready_o[i] & !flush_i writes {trans_id, result, exception} at the tail of FIFO i.
- src_ready_o[i]:
  - Equals !full[i]. A pop in the same cycle is not credited.
  - A valid while full drops the entry and sets overflow_o. overflow_o clears only on reset.
- Grant (combinational):
  - Takes the first non-empty FIFO searching from rr and wrapping modulo NR_SRC.
  - wb_valid_o = any FIFO non-empty & !flush_i.
  - Outputs show the head of the granted FIFO. When wb_valid_o=0 the data outputs are 0.
- Pop: wb_valid_o & wb_ready_i removes the head of the granted FIFO; rr <= (granted+1) mod NR_SRC.
  - If wb_ready_i=0, the grant and all outputs stay stable. The grant does not change while stalled, even if a higher-priority source fills.
- Latency: 1 cycle from push to wb_valid_o when idle. Sustained throughput: 1 entry/cycle.
- Simultaneous push and pop on the same FIFO (not full): both happen; occupancy is unchanged.
- Pointer rules:
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits.
  - full = MSBs differ and LSBs equal.
  - Wrap-around is natural modulo 2*FIFO_DEPTH.
- Flush:
  - All FIFOs are emptied at the next edge.
  - Pushes in the flush cycle are dropped and do not set overflow.
  - wb_valid_o=0 during flush_i. rr is unchanged.
- Per-source order is strictly FIFO. There is no ordering guarantee between different sources.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- Defined:
  - If the granted-candidate search finds every FIFO empty, an incoming src_valid_i is forwarded combinationally in the same cycle. Among multiple incoming sources, selection uses the same rr order.
  - If the bypassed entry is accepted (wb_ready_i=1), it is not written to its FIFO and rr advances.
  - If it is not accepted, it is written to its FIFO as normal.
  - Idle latency becomes 0 cycles.
- Undefined: no bypass; idle latency is 1 cycle.

Test Plan:
- Reset, then a single push src 1 (id=3, result=0xDEAD) with wb_ready_i=1 -> wb_valid_o=1 the next cycle, wb_src_o=1, trans_id=3, result=0xDEAD; rr becomes 2. With bypass enabled, the same values appear in the push cycle.
- All 5 sources push in one cycle, wb_ready_i=1, rr=0 -> grants in order 0,1,2,3,4 over 5 consecutive cycles, then wb_valid_o=0.
- wb_ready_i=0 and source 3 pushes 3 times with FIFO_DEPTH=2 -> src_ready_o[3]=0 after 2 pushes, the third is dropped, overflow_o=1 and stays 1 after draining.
- Stall: wb_ready_i=0 for 4 cycles with src 2 granted, then src 0 pushes -> outputs unchanged during the stall; src 2 pops first, then src 0.
- Source 4 FIFO full and flush_i pulsed with a concurrent push -> next cycle all FIFOs empty, wb_valid_o=0, overflow_o unchanged.
- Wrap: stream 10 entries through source 0 at 1/cycle -> IDs emerge in order with no loss and src_ready_o[0] stays 1.
